muldiv_seq: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/md_step.sv | 27 ++
 rtl/muldiv_seq.sv | 117 +++++++++++
 tb/tb_muldiv_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the HI/LO multiply/divide sequencer.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_t;

    // Quotient reported for divide by zero; sliced down to the operand width.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration, either shift-add multiply or restoring divide.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    input  logic               i_is_div,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
        w_trial = i_acc[2*WIDTH-1:WIDTH-1];
        // The true difference is below the divisor when it fits, so the low bits suffice.
        w_diff  = w_trial[WIDTH-1:0] - i_operand;
        w_fits  = w_trial >= {1'b0, i_operand};
        o_acc   = !i_is_div ? {w_sum, i_acc[WIDTH-1:1]} :
                  w_fits    ? {w_diff, i_acc[WIDTH-2:0], 1'b1} :
                              {i_acc[2*WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle mult/multu/div/divu sequencer owning HI/LO,
// with the stall that holds dependent HI/LO accesses until the result lands.
module muldiv_seq
    import mips_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StartE,
    input  logic [1:0]       MDOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiWriteE,
    input  logic             LoWriteE,
    input  logic             HiLoReadD,
    input  logic             AbortE,
    output logic             Busy,
    output logic             StallMD,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    md_state_t          r_state, w_next;
    md_op_t             r_op;
    logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
    logic [WIDTH-1:0]   r_opnd, r_dividend, r_hi, r_lo;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quo, w_rem, w_res_hi, w_res_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_a, r_neg_b;
    logic               w_in_signed, w_neg_a, w_neg_b, w_accept, w_is_div, w_div0, w_fix;

    md_step #(.WIDTH(WIDTH)) u_step (
        .i_acc    (r_acc),
        .i_operand(r_opnd),
        .i_is_div (w_is_div),
        .o_acc    (w_step)
    );

    always_comb begin
        w_in_signed = MDOpE == MD_MULT || MDOpE == MD_DIV;
        w_neg_a     = w_in_signed & SrcAE[WIDTH-1];
        w_neg_b     = w_in_signed & SrcBE[WIDTH-1];
        w_mag_a     = w_neg_a ? -SrcAE : SrcAE;
        w_mag_b     = w_neg_b ? -SrcBE : SrcBE;
        w_accept    = r_state == IDLE && StartE && !AbortE;
        w_is_div    = r_op == MD_DIV || r_op == MD_DIVU;
        w_div0      = r_opnd == '0;
        w_fix       = r_state == FIX && !AbortE;
        // Sign flags are only ever set for signed ops, so unsigned results pass through.
        w_prod      = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
        w_quo       = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem       = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_hi    = !w_is_div ? w_prod[2*WIDTH-1:WIDTH] : w_div0 ? r_dividend : w_rem;
        w_res_lo    = !w_is_div ? w_prod[WIDTH-1:0] : w_div0 ? DIV0_QUOT[WIDTH-1:0] : w_quo;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = AbortE ? IDLE : (r_cnt == CNT_W'(1) ? FIX : RUN);
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= MD_MULT;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_op       <= md_op_t'(MDOpE);
            r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
            r_opnd     <= w_mag_b;
            r_dividend <= SrcAE;
            r_neg_a    <= w_neg_a;
            r_neg_b    <= w_neg_b;
            r_cnt      <= CNT_W'(WIDTH);
        end else if (r_state == RUN) begin
            r_acc      <= w_step;
            r_cnt      <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_fix) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == IDLE) begin
            if (HiWriteE) r_hi <= SrcAE;
            if (LoWriteE) r_lo <= SrcAE;
        end
    end

    assign Busy    = r_state != IDLE;
    assign StallMD = Busy & (StartE | HiLoReadD | HiWriteE | LoWriteE);
    assign DivZero = w_fix & w_is_div & w_div0;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against a 64-bit arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MDOpE = 2'b00;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        HiWriteE = 1'b0;
    logic        LoWriteE = 1'b0;
    logic        HiLoReadD = 1'b0;
    logic        AbortE = 1'b0;
    logic        Busy, StallMD, DivZero;
    logic [31:0] HI, LO;

    int total = 0;
    int bad = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .StartE(StartE), .MDOpE(MDOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .HiWriteE(HiWriteE), .LoWriteE(LoWriteE),
        .HiLoReadD(HiLoReadD), .AbortE(AbortE), .Busy(Busy), .StallMD(StallMD),
        .DivZero(DivZero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output int dz);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p, q, r;
        dz = 0;
        p = '0; q = '0; r = '0;
        case (op)
            2'd0: p = sa * sb;
            2'd1: p = ua * ub;
            2'd2: if (b != 0) begin q = sa / sb; r = sa % sb; end
            default: if (b != 0) begin q = ua / ub; r = ua % ub; end
        endcase
        if (op[1] && b == 0) begin
            hi = a; lo = 32'hFFFF_FFFF; dz = 1;
        end else if (op[1]) begin
            hi = r[31:0]; lo = q[31:0];
        end else begin
            hi = p[63:32]; lo = p[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        StartE = 1'b1; MDOpE = op; SrcAE = a; SrcBE = b;
        @(negedge clk);
        StartE = 1'b0;
    endtask

    task automatic wait_op(output int cyc, output int dz);
        cyc = 0; dz = 0;
        while (Busy && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (DivZero) dz++;
        end
    endtask

    task automatic test_reset();
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        total++; if (DivZero !== 1'b0) begin bad++; $display("FAIL reset_divzero got=%b exp=0", DivZero); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops [6] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd3};
        logic [31:0] as  [6] = '{32'hFFFF_FFFF, -32'sd7, -32'sd7, 32'd100, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] eh, el;
        int edz, cyc, dz;
        for (int i = 0; i < 6; i++) begin
            model(ops[i], as[i], bs[i], eh, el, edz);
            start_op(ops[i], as[i], bs[i]);
            wait_op(cyc, dz);
            total++; if (cyc != 33) begin bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=33", i, cyc); end
            total++; if (HI !== eh) begin bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, HI, eh); end
            total++; if (LO !== el) begin bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, LO, el); end
            total++; if (dz != edz) begin bad++; $display("FAIL dir%0d_divzero_pulses got=%0d exp=%0d", i, dz, edz); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] eh, el;
        int edz, n, stall_bad;
        model(2'd0, -32'sd7, 32'd3, eh, el, edz);
        start_op(2'd0, -32'sd7, 32'd3);
        repeat (4) @(negedge clk);
        HiLoReadD = 1'b1;
        n = 0; stall_bad = 0;
        while (Busy && n < 100) begin
            if (n == 5) begin StartE = 1'b1; MDOpE = 2'd3; SrcAE = 32'd100; SrcBE = 32'd7; end
            else StartE = 1'b0;
            #1;
            if (StallMD !== 1'b1) stall_bad++;
            @(negedge clk);
            n++;
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_held got=%0d low cycles exp=0", stall_bad); end
        total++; if (n + 4 != 33) begin bad++; $display("FAIL stall_busy_cycles got=%0d exp=33", n + 4); end
        total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", StallMD); end
        HiLoReadD = 1'b0;
        total++; if (HI !== eh) begin bad++; $display("FAIL stall_hi got=%h exp=%h", HI, eh); end
        total++; if (LO !== el) begin bad++; $display("FAIL stall_lo got=%h exp=%h", LO, el); end
    endtask

    task automatic test_abort();
        logic [31:0] eh, el;
        int edz, cyc, dz;
        HiWriteE = 1'b1; SrcAE = 32'h1234;
        @(negedge clk);
        HiWriteE = 1'b0; LoWriteE = 1'b1; SrcAE = 32'h5678;
        @(negedge clk);
        LoWriteE = 1'b0;
        total++; if (HI !== 32'h1234) begin bad++; $display("FAIL mthi got=%h exp=1234", HI); end
        total++; if (LO !== 32'h5678) begin bad++; $display("FAIL mtlo got=%h exp=5678", LO); end
        StartE = 1'b1; AbortE = 1'b1; MDOpE = 2'd0;
        @(negedge clk);
        StartE = 1'b0; AbortE = 1'b0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_idle_start got busy=%b exp=0", Busy); end
        start_op(2'd0, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        AbortE = 1'b1;
        @(negedge clk);
        AbortE = 1'b0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_run_busy got=%b exp=0", Busy); end
        total++; if (HI !== 32'h1234) begin bad++; $display("FAIL abort_run_hi got=%h exp=1234", HI); end
        total++; if (LO !== 32'h5678) begin bad++; $display("FAIL abort_run_lo got=%h exp=5678", LO); end
        model(2'd3, 32'd100, 32'd7, eh, el, edz);
        start_op(2'd3, 32'd100, 32'd7);
        wait_op(cyc, dz);
        total++; if (cyc != 33) begin bad++; $display("FAIL after_abort_cycles got=%0d exp=33", cyc); end
        total++; if (HI !== eh || LO !== el) begin bad++; $display("FAIL after_abort_result got=%h_%h exp=%h_%h", HI, LO, eh, el); end
        start_op(2'd3, 32'd5, 32'd0);
        repeat (32) @(negedge clk);
        AbortE = 1'b1;
        #1;
        total++; if (DivZero !== 1'b0) begin bad++; $display("FAIL abort_fix_divzero got=%b exp=0", DivZero); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL abort_fix_in_fix got busy=%b exp=1", Busy); end
        @(negedge clk);
        AbortE = 1'b0;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_fix_busy got=%b exp=0", Busy); end
        total++; if (HI !== eh || LO !== el) begin bad++; $display("FAIL abort_fix_result got=%h_%h exp=%h_%h", HI, LO, eh, el); end
    endtask

    task automatic test_start_in_fix();
        logic [31:0] h1, l1, h2, l2, a2, b2;
        int d1, d2, cyc, dz;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        model(2'd1, 32'hDEAD_BEEF, 32'h0000_1001, h1, l1, d1);
        model(2'd2, a2, b2, h2, l2, d2);
        start_op(2'd1, 32'hDEAD_BEEF, 32'h0000_1001);
        repeat (32) @(negedge clk);
        StartE = 1'b1; MDOpE = 2'd2; SrcAE = a2; SrcBE = b2;
        #1;
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL fix_start_busy got=%b exp=1", Busy); end
        @(negedge clk);
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL fix_start_ignored got busy=%b exp=0", Busy); end
        total++; if (StallMD !== 1'b0) begin bad++; $display("FAIL fix_start_nostall got=%b exp=0", StallMD); end
        total++; if (HI !== h1 || LO !== l1) begin bad++; $display("FAIL fix_first_result got=%h_%h exp=%h_%h", HI, LO, h1, l1); end
        @(negedge clk);
        StartE = 1'b0;
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL fix_start_accepted got busy=%b exp=1", Busy); end
        wait_op(cyc, dz);
        total++; if (cyc != 33) begin bad++; $display("FAIL fix_second_cycles got=%0d exp=33", cyc); end
        total++; if (HI !== h2 || LO !== l2) begin bad++; $display("FAIL fix_second_result got=%h_%h exp=%h_%h", HI, LO, h2, l2); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
        logic [1:0]  o1, o2;
        int d1, d2, cyc, dz;
        o1 = 2'($urandom_range(0, 3)); a1 = pick(); b1 = pick();
        o2 = 2'($urandom_range(0, 3)); a2 = pick(); b2 = pick();
        model(o1, a1, b1, h1, l1, d1);
        model(o2, a2, b2, h2, l2, d2);
        HiWriteE = 1'b1;
        start_op(o1, a1, b1);
        HiWriteE = 1'b0;
        total++; if (HI !== a1) begin bad++; $display("FAIL b2b_mthi_with_start got=%h exp=%h", HI, a1); end
        wait_op(cyc, dz);
        total++; if (HI !== h1 || LO !== l1 || dz != d1) begin bad++; $display("FAIL b2b_first got=%h_%h dz=%0d exp=%h_%h dz=%0d", HI, LO, dz, h1, l1, d1); end
        start_op(o2, a2, b2);
        wait_op(cyc, dz);
        total++; if (HI !== h2 || LO !== l2 || cyc != 33) begin bad++; $display("FAIL b2b_second got=%h_%h cyc=%0d exp=%h_%h cyc=33", HI, LO, cyc, h2, l2); end
    endtask

    task automatic test_async_reset();
        start_op(2'd2, -32'sd7, 32'd2);
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL areset_busy got=%b exp=0", Busy); end
        total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL areset_hilo got=%h_%h exp=0_0", HI, LO); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (Busy !== 1'b0 || HI !== 32'h0) begin bad++; $display("FAIL areset_release got busy=%b hi=%h exp=0", Busy, HI); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eh, el;
        logic [1:0]  op;
        int edz, cyc, dz;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
            model(op, a, b, eh, el, edz);
            start_op(op, a, b);
            wait_op(cyc, dz);
            total++;
            if (HI !== eh || LO !== el || dz != edz || cyc != 33) begin
                bad++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got=%h_%h dz=%0d cyc=%0d exp=%h_%h dz=%0d cyc=33",
                         i, op, a, b, HI, LO, dz, cyc, eh, el, edz);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_abort();
        test_start_in_fix();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
